// File: rtl/mac_pkg.sv
// Shared types, saturation bounds and parameter legality check for the
// pipelined multiply-accumulate unit.
package mac_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } overflow_mode_e;

    localparam int MIN_MULT_STAGES = 1;
    localparam int MAX_MULT_STAGES = 3;
    localparam int MAX_ACC_W       = 64;

    // Bounds are returned at 64 bits; callers size-cast to their accumulator width.
    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    function automatic bit params_ok(input int in_w, input int acc_w, input int mult_stages);
        return (in_w >= 1) && (acc_w >= 2 * in_w) && (acc_w <= MAX_ACC_W) &&
               (mult_stages >= MIN_MULT_STAGES) && (mult_stages <= MAX_MULT_STAGES);
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Registered signed multiplier: MULT_STAGES product registers, with the
// valid and first tags carried alongside every stage.
module mac_mult_pipe
    import mac_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int MULT_STAGES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic                     first_i,
    input  logic signed [IN_W-1:0]   a_i,
    input  logic signed [IN_W-1:0]   b_i,
    output logic signed [2*IN_W-1:0] p_o,
    output logic                     valid_o,
    output logic                     first_o
);

    localparam int P_W = 2 * IN_W;

    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   p_d;
    logic signed [P_W-1:0]   p_q     [MULT_STAGES];
    logic [MULT_STAGES-1:0]  valid_q;
    logic [MULT_STAGES-1:0]  first_q;

    // Operands are widened first so the product is exact, including min*min.
    assign a_ext = P_W'(a_i);
    assign b_ext = P_W'(b_i);
    assign p_d   = a_ext * b_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                p_q[i] <= '0;
            end
            valid_q <= '0;
            first_q <= '0;
        end else begin
            p_q[0]     <= p_d;
            valid_q[0] <= valid_i;
            first_q[0] <= first_i;
            for (int i = 1; i < MULT_STAGES; i++) begin
                p_q[i]     <= p_q[i-1];
                valid_q[i] <= valid_q[i-1];
                first_q[i] <= first_q[i-1];
            end
        end
    end

    assign p_o     = p_q[MULT_STAGES-1];
    assign valid_o = valid_q[MULT_STAGES-1];
    assign first_o = first_q[MULT_STAGES-1];

endmodule

// File: rtl/mac_pipe_acc.sv
// Pipelined signed multiply-accumulate: input register, multiplier stages,
// accumulator with wrap/saturate overflow handling and a sticky overflow flag.
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int ACC_W       = 16,
    parameter int MULT_STAGES = 1,
    parameter int SATURATE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    first_in,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out,
    output logic                    overflow
);

    generate
        if (!params_ok(IN_W, ACC_W, MULT_STAGES)) begin : g_bad_params
            $error("mac_pipe_acc: illegal IN_W/ACC_W/MULT_STAGES combination");
        end
    endgenerate

    localparam overflow_mode_e         MODE  = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic signed [ACC_W-1:0] F_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] F_MIN = ACC_W'(sat_min(ACC_W));

    // Stream contract: a sample is consumed on every rising edge where
    // valid_in=1; there is no ready. valid_out=1 marks the one cycle on which
    // f reflects that sample; otherwise f and overflow simply hold.
    logic signed [IN_W-1:0]   a_q;
    logic signed [IN_W-1:0]   b_q;
    logic                     in_valid_q;
    logic                     in_first_q;

    logic signed [2*IN_W-1:0] p;
    logic                     p_valid;
    logic                     p_first;

    logic signed [ACC_W-1:0]  p_ext;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf_step;

    logic signed [ACC_W-1:0]  f_q,   f_d;
    logic                     ovf_q, ovf_d;
    logic                     out_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            in_valid_q <= 1'b0;
            in_first_q <= 1'b0;
        end else begin
            a_q        <= a;
            b_q        <= b;
            in_valid_q <= valid_in;
            in_first_q <= first_in & valid_in;
        end
    end

    mac_mult_pipe #(
        .IN_W        (IN_W),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .valid_i (in_valid_q),
        .first_i (in_first_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .p_o     (p),
        .valid_o (p_valid),
        .first_o (p_first)
    );

    // A first-tagged sample accumulates from zero, which can never overflow.
    assign p_ext    = ACC_W'(p);
    assign base     = p_first ? '0 : f_q;
    assign sum      = base + p_ext;
    assign ovf_step = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);

    always_comb begin
        f_d   = f_q;
        ovf_d = ovf_q;
        if (p_valid) begin
            ovf_d = (p_first ? 1'b0 : ovf_q) | ovf_step;
            if (ovf_step && (MODE == MODE_SAT)) begin
                f_d = base[ACC_W-1] ? F_MIN : F_MAX;
            end else begin
                f_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            ovf_q       <= ovf_d;
            out_valid_q <= p_valid;
        end
    end

    assign f         = f_q;
    assign overflow  = ovf_q;
    assign valid_out = out_valid_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Bench for mac_pipe_acc: three instances (wrap/1 stage, saturate/1 stage,
// wrap/3 stages) share one stimulus stream and are compared to integer models.
module tb_mac_pipe_acc;

    localparam int  ND       = 3;
    localparam bit  SAT_D[3] = '{1'b0, 1'b1, 1'b0};
    localparam int  LAT_D[3] = '{3, 3, 5};
    localparam int  F_MAXV   = 32767;
    localparam int  F_MINV   = -32768;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic              first_in;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [15:0] f_o [ND];
    logic              vo [ND];
    logic              ov [ND];

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  cap_en = 1'b0;

    // Per-cycle trace word: {valid_out, overflow, f}
    logic [17:0] exp_q [ND][$];
    logic [17:0] obs_q [ND][$];

    int  f_m   [ND];
    bit  ovf_m [ND];

    mac_pipe_acc #(.IN_W(8), .ACC_W(16), .MULT_STAGES(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b), .first_in(first_in),
        .f(f_o[0]), .valid_out(vo[0]), .overflow(ov[0]));

    mac_pipe_acc #(.IN_W(8), .ACC_W(16), .MULT_STAGES(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b), .first_in(first_in),
        .f(f_o[1]), .valid_out(vo[1]), .overflow(ov[1]));

    mac_pipe_acc #(.IN_W(8), .ACC_W(16), .MULT_STAGES(3), .SATURATE(0)) dut_deep (
        .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b), .first_in(first_in),
        .f(f_o[2]), .valid_out(vo[2]), .overflow(ov[2]));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Passive trace capture, 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cap_en) begin
                for (int d = 0; d < ND; d++) obs_q[d].push_back({vo[d], ov[d], f_o[d]});
            end
        end
    end

    // ---------------- driver tasks + reference model ----------------
    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            f_m[d]   = 0;
            ovf_m[d] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus (called at a falling edge) and advance the model.
    task automatic send(input bit v, input int av, input int bv, input bit fi);
        int s;
        valid_in = v;
        a        = av[7:0];
        b        = bv[7:0];
        first_in = fi;
        for (int d = 0; d < ND; d++) begin
            if (v) begin
                if (fi) ovf_m[d] = 1'b0;
                s = (fi ? 0 : f_m[d]) + av * bv;
                if (s > F_MAXV || s < F_MINV) begin
                    ovf_m[d] = 1'b1;
                    if (SAT_D[d]) s = (s > 0) ? F_MAXV : F_MINV;
                    else          s = int'($signed(16'(s)));
                end
                f_m[d] = s;
            end
            exp_q[d].push_back({v, ovf_m[d], 16'(f_m[d])});
        end
        @(negedge clk);
    endtask

    task automatic bubble();
        send(1'b0, rnd8(), rnd8(), 1'($urandom_range(0, 1)));
    endtask

    task automatic begin_capture();
        for (int d = 0; d < ND; d++) begin
            obs_q[d].delete();
            exp_q[d].delete();
            for (int i = 0; i < LAT_D[d] - 1; i++) exp_q[d].push_back({1'b0, ovf_m[d], 16'(f_m[d])});
        end
        cap_en = 1'b1;
    endtask

    task automatic end_capture();
        repeat (6) bubble();
        cap_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        first_in = 1'b0;
        a        = '0;
        b        = '0;
        model_clear();
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if ({vo[d], ov[d], f_o[d]} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_state d%0d: got v=%0b o=%0b f=%0d, want all zero",
                         d, vo[d], ov[d], f_o[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [17:0] got, want;
        begin_capture();
        send(1'b1, 2, 2, 1'b0);
        send(1'b1, 3, -3, 1'b0);
        send(1'b0, 5, 5, 1'b0);
        send(1'b1, 50, 15, 1'b0);
        end_capture();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                got = obs_q[d][i]; want = exp_q[d][i];
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL basic d%0d step %0d: got v=%0b o=%0b f=%0d, want v=%0b o=%0b f=%0d",
                             d, i, got[17], got[16], $signed(got[15:0]), want[17], want[16], $signed(want[15:0]));
                end
            end
        end
    endtask

    task automatic test_overflow_pos();
        logic [17:0] got, want;
        begin_capture();
        send(1'b1, 125, 100, 1'b1);
        send(1'b1, 125, 100, 1'b0);
        send(1'b1, 125, 100, 1'b0);
        send(1'b1, 100, 2, 1'b0);
        send(1'b1, -125, 120, 1'b0);
        end_capture();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                got = obs_q[d][i]; want = exp_q[d][i];
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL overflow_pos d%0d step %0d: got v=%0b o=%0b f=%0d, want v=%0b o=%0b f=%0d",
                             d, i, got[17], got[16], $signed(got[15:0]), want[17], want[16], $signed(want[15:0]));
                end
            end
        end
    endtask

    task automatic test_overflow_neg();
        logic [17:0] got, want;
        begin_capture();
        send(1'b1, -125, 120, 1'b1);
        send(1'b1, -125, 120, 1'b0);
        bubble();
        send(1'b1, -125, 120, 1'b0);
        end_capture();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                got = obs_q[d][i]; want = exp_q[d][i];
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL overflow_neg d%0d step %0d: got v=%0b o=%0b f=%0d, want v=%0b o=%0b f=%0d",
                             d, i, got[17], got[16], $signed(got[15:0]), want[17], want[16], $signed(want[15:0]));
                end
            end
        end
    endtask

    task automatic test_restart();
        logic [17:0] got, want;
        begin_capture();
        send(1'b1, 2, 2, 1'b1);
        send(1'b1, -3, 3, 1'b0);
        send(1'b1, -128, -128, 1'b1);
        send(1'b1, 10, 10, 1'b1);
        send(1'b0, 7, 7, 1'b1);
        send(1'b1, 1, 1, 1'b0);
        end_capture();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                got = obs_q[d][i]; want = exp_q[d][i];
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL restart d%0d step %0d: got v=%0b o=%0b f=%0d, want v=%0b o=%0b f=%0d",
                             d, i, got[17], got[16], $signed(got[15:0]), want[17], want[16], $signed(want[15:0]));
                end
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [17:0] got, want;
        begin_capture();
        for (int k = 0; k < 400; k++) begin
            send(1'($urandom_range(0, 3) != 0), rnd8(), rnd8(), 1'($urandom_range(0, 9) == 0));
        end
        end_capture();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                got = obs_q[d][i]; want = exp_q[d][i];
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL random d%0d step %0d: got v=%0b o=%0b f=%0d, want v=%0b o=%0b f=%0d",
                             d, i, got[17], got[16], $signed(got[15:0]), want[17], want[16], $signed(want[15:0]));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [17:0] got, want;
        // Leave every instance with overflow set and a non-zero accumulator.
        send(1'b1, 125, 100, 1'b1);
        send(1'b1, 125, 100, 1'b0);
        send(1'b1, 125, 100, 1'b0);
        repeat (6) bubble();
        send(1'b1, 9, 9, 1'b0);
        send(1'b1, 1, 2, 1'b0);
        send(1'b1, 3, 3, 1'b0);
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if ({vo[d], ov[d], f_o[d]} !== 18'd0) begin
                n_fail++;
                $display("FAIL async_reset d%0d: got v=%0b o=%0b f=%0d, want all zero",
                         d, vo[d], ov[d], f_o[d]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        begin_capture();
        end_capture();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                got = obs_q[d][i]; want = exp_q[d][i];
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL post_reset d%0d step %0d: got v=%0b o=%0b f=%0d, want v=%0b o=%0b f=%0d",
                             d, i, got[17], got[16], $signed(got[15:0]), want[17], want[16], $signed(want[15:0]));
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_overflow_pos();
        test_restart();
        test_overflow_neg();
        test_restart();
        test_back_to_back_random();
        test_reset_midstream();
        test_basic();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_pipe_acc.md
Name: mac_pipe_acc

Overview:
- Parametrised, pipelined signed multiply-accumulate unit: a*b products summed into an ACC_W-bit accumulator.
- Adds configurable multiplier pipeline depth, wrap/saturate overflow mode, and an in-band first_in tag that restarts accumulation without a reset.
- Sits as a datapath element fed by a valid-qualified sample stream. No back-pressure.

Parameters:
- IN_W, 8, signed operand width (a, b).
- ACC_W, 16, accumulator/output width. Must be >= 2*IN_W; elaboration fails otherwise.
- MULT_STAGES, 1, product register stages, 1..3. Values outside this range fail elaboration.
- SATURATE, 0, 0 = two's-complement wrap on overflow; 1 = clamp to max/min.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- valid_in  in  1  a, b and first_in are valid this cycle.
- a  in  IN_W  signed operand.
- b  in  IN_W  signed operand.
- first_in  in  1  this sample starts a new accumulation; sampled only when valid_in=1.
- f  out  ACC_W  signed accumulator value.
- valid_out  out  1  f was updated by a sample on this cycle.
- overflow  out  1  sticky overflow flag for the current accumulation.

Behaviour:
- Reset (async, reset=1): all pipeline registers, tags, f, valid_out and overflow go to 0 immediately. In-flight samples are discarded.
- Pipeline: input register (1 stage), then MULT_STAGES product stages, then accumulator register (1 stage).
  - Latency valid_in -> valid_out = MULT_STAGES+2 cycles (3 at default).
  - One sample per cycle is accepted; throughput is 1.
- valid and first tags travel alongside the data. When valid_in=0, a bubble propagates: f holds its value and valid_out=0 on the corresponding cycle.
- Product: full 2*IN_W signed product, sign-extended to ACC_W. -2^(IN_W-1) * -2^(IN_W-1) is exact.
- Accumulate step (valid tag=1):
  - first tag=1: sum = 0 + p, and the overflow flag is cleared before being evaluated on this step.
  - first tag=0: sum = f + p.
- Overflow detection: f and p have the same sign and the sum sign differs (ACC_W+1-bit compare equivalent).
  - When it fires, overflow is set and stays set until reset or an accumulate step tagged first.
- On overflow:
  - SATURATE=0: f = wrapped ACC_W-bit sum.
  - SATURATE=1: f = 2^(ACC_W-1)-1 when the sum is positive, -2^(ACC_W-1) when negative. Later sums start from the clamped value.
- overflow updates on the same edge as f, and also holds during bubbles.
- first_in with valid_in=0 has no effect.
- After reset, the first sample accumulates from f=0 whether or not first_in is set.

Decomposition:
- Package mac_pkg holds:
  - typedef overflow_mode_e {MODE_WRAP, MODE_SAT};
  - functions sat_max(ACC_W) and sat_min(ACC_W);
  - the param range check.
- Sub-module mac_mult_pipe: registered signed multiplier with MULT_STAGES stages, carrying valid/first sideband bits; it clears on reset.
- The top level holds the input register, the accumulator, overflow/saturation logic and the sticky flag.

Test Plan (IN_W=8, ACC_W=16, MULT_STAGES=1 unless noted):
- Basic stream: reset, then samples (2,2) v, (3,-3) v, (5,5) v=0, (50,15) v.
  - valid_out = 1,1,0,1 starting 3 cycles after the first sample.
  - f = 4, -5, -5(hold), 745; overflow=0.
- Wrap overflow (SATURATE=0): (125,100) x3 with first_in on the first sample.
  - f = 12500, 25000, -28036; overflow rises on the third and stays 1.
  - Then (100,2) gives f = -27836, overflow=1.
- Saturate (SATURATE=1): (125,100) x3 gives f = 12500, 25000, 32767, overflow=1.
  - Then (-125,120) gives f = 17767, overflow still 1.
- Negative direction: first_in (-125,120) x3.
  - Wrap: f = -15000, -30000, 20536, overflow=1.
  - Saturate: f = -15000, -30000, -32768, overflow=1.
- Restart: after an overflow, (2,2) with first_in gives f=4, overflow=0.
  - Next, (-3,3) gives f=-5.
  - (-128,-128) with first_in gives f=16384, no overflow.
- Reset mid-stream and depth: assert reset with 3 samples in flight.
  - f, valid_out and overflow go to 0 asynchronously; no valid_out follows.
  - Repeat the basic stream with MULT_STAGES=3: latency is 5 cycles, same f values.
